// File: rtl/qam_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : qam_mapper
//  Description : Serial-bit to QPSK / 16-QAM / 64-QAM constellation mapper
//                with 802.11a Gray mapping and signed fixed-point I/Q output
//                over a valid/ready handshake. Mode is runtime-selectable and
//                latched at the first beat of each symbol.
//                Optional macro QAM_NORM_EN selects unit-average-energy
//                scaling from a constant table (IQ_W <= 31 in that build);
//                otherwise levels are scaled by a plain left shift.
//  Revision    : 1.0  initial release
// ============================================================================
module qam_mapper #(
    parameter int IN_BITS = 2,   // 1 or 2
    parameter int IQ_W    = 16   // >= 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   flush,
    input  logic [IN_BITS-1:0]     in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic signed [IQ_W-1:0] out_i,
    output logic signed [IQ_W-1:0] out_q,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   err_mode
);

    localparam logic [1:0] c_MODE_QPSK = 2'd0;
    localparam logic [1:0] c_MODE_16   = 2'd1;
    localparam logic [1:0] c_MODE_64   = 2'd2;
    localparam logic [1:0] c_MODE_RSV  = 2'd3;

`ifdef QAM_NORM_EN
    // Table entries are level/sqrt(Es) in Q30; reduce to Q(IQ_W-2) with rounding.
    localparam int          c_NSH = 32 - IQ_W;
    localparam logic [32:0] c_RND = 33'(1) << (c_NSH - 1);
`else
    localparam int c_SH = IQ_W - 5;
`endif

    // Axis value from sign bit and magnitude index (index n means level 2n+1).
    function automatic logic [IQ_W-1:0] axis_val(input logic [1:0] m,
                                                 input logic       pos,
                                                 input logic [1:0] mi);
        logic [IQ_W-1:0] mag;
`ifdef QAM_NORM_EN
        logic [32:0] q30;
        case (m)
            c_MODE_QPSK: q30 = 33'd759250125;
            c_MODE_16:   q30 = mi[0] ? 33'd1018640937 : 33'd339546979;
            default: begin
                case (mi)
                    2'd0:    q30 = 33'd165681960;
                    2'd1:    q30 = 33'd497045880;
                    2'd2:    q30 = 33'd828409800;
                    default: q30 = 33'd1159773720;
                endcase
            end
        endcase
        mag = IQ_W'((q30 + c_RND) >> c_NSH);
`else
        mag = IQ_W'({mi, 1'b1}) << c_SH;
`endif
        return pos ? mag : (IQ_W'(0) - mag);
    endfunction

    logic [1:0]      r_mode;
    logic [2:0]      r_count;
    logic [5:0]      r_acc;
    logic            r_err;
    logic [IQ_W-1:0] r_out_i;
    logic [IQ_W-1:0] r_out_q;
    logic            r_out_valid;
    logic            r_out_last;

    logic            w_accept;
    logic [1:0]      w_mode_eff;
    logic [2:0]      w_k;
    logic [3:0]      w_cnt_next;
    logic [5:0]      w_bits;
    logic            w_complete;
    logic            w_i_pos;
    logic            w_q_pos;
    logic [1:0]      w_i_mi;
    logic [1:0]      w_q_mi;
    logic [IQ_W-1:0] w_i;
    logic [IQ_W-1:0] w_q;

    assign in_ready  = ~flush & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign err_mode  = r_err;

    // Symbol assembly and Gray demux of the bits completed on this beat.
    always_comb begin
        w_mode_eff = r_mode;
        if (r_count == 3'd0) begin
            w_mode_eff = (mode == c_MODE_RSV) ? c_MODE_QPSK : mode;
        end

        case (w_mode_eff)
            c_MODE_QPSK: w_k = 3'd2;
            c_MODE_16:   w_k = 3'd4;
            default:     w_k = 3'd6;
        endcase

        // Unreceived positions stay zero, which gives the padding on in_last.
        w_bits     = r_acc | (6'(in_data) << r_count);
        w_cnt_next = 4'(r_count) + 4'(IN_BITS);
        w_complete = w_accept & ((w_cnt_next >= {1'b0, w_k}) | in_last);

        case (w_mode_eff)
            c_MODE_QPSK: begin
                w_i_pos = w_bits[0];
                w_i_mi  = 2'd0;
                w_q_pos = w_bits[1];
                w_q_mi  = 2'd0;
            end
            c_MODE_16: begin
                w_i_pos = w_bits[0];
                w_i_mi  = {1'b0, ~w_bits[1]};
                w_q_pos = w_bits[2];
                w_q_mi  = {1'b0, ~w_bits[3]};
            end
            default: begin
                w_i_pos = w_bits[0];
                w_i_mi  = {~w_bits[1], ~(w_bits[1] ^ w_bits[2])};
                w_q_pos = w_bits[3];
                w_q_mi  = {~w_bits[4], ~(w_bits[4] ^ w_bits[5])};
            end
        endcase

        w_i = axis_val(w_mode_eff, w_i_pos, w_i_mi);
        w_q = axis_val(w_mode_eff, w_q_pos, w_q_mi);
    end

    // Bit collection, mode latch, sticky error and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= c_MODE_QPSK;
            r_count     <= 3'd0;
            r_acc       <= 6'd0;
            r_err       <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (flush) begin
                r_count <= 3'd0;
                r_acc   <= 6'd0;
            end else if (w_accept) begin
                if (r_count == 3'd0) begin
                    r_mode <= w_mode_eff;
                    if (mode == c_MODE_RSV) begin
                        r_err <= 1'b1;
                    end
                end
                if (w_complete) begin
                    r_count <= 3'd0;
                    r_acc   <= 6'd0;
                end else begin
                    r_count <= w_cnt_next[2:0];
                    r_acc   <= w_bits;
                end
            end

            // A new symbol may overwrite one being handed off this same cycle.
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_i     <= w_i;
                r_out_q     <= w_q;
                r_out_last  <= in_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
